// File: rtl/register_16b_pkg.sv
// register_16b_pkg: shared widths, types and reset value for the byte-loadable holding register
package register_16b_pkg;
  localparam int HALF_W_DEFAULT = 8;
  localparam int FULL_W_DEFAULT = 16;
  typedef logic [7:0] half_t;
  typedef logic [15:0] word_t;
  localparam word_t WORD_RESET = 16'h0000;
endpackage

// File: rtl/register_16b_reg_half_en.sv
// reg_half_en: one half of the holding register, async active-low clear and sync load enable
module reg_half_en #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or negedge reset)
    if (!reset) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/register_16b.sv
// register_16b: 16-bit register assembled from an 8-bit bus, one half per strobe.
// Define REGISTER_16B_ASSERT_EN to compile in protocol/behaviour assertions.
module register_16b
  import register_16b_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              loadhigh,
  input  logic              loadlow,
  input  logic [HALF_W-1:0] halfvaluein,
  output logic [2*HALF_W-1:0] valueout
);
  logic [HALF_W-1:0] hi, lo;
  // loadhigh wins when both strobes are asserted together
  reg_half_en #(.W(HALF_W)) u_hi (
    .clock(clock), .reset(reset), .en(loadhigh), .d(halfvaluein), .q(hi)
  );
  reg_half_en #(.W(HALF_W)) u_lo (
    .clock(clock), .reset(reset), .en(loadlow & ~loadhigh), .d(halfvaluein), .q(lo)
  );
  assign valueout = {hi, lo};
`ifdef REGISTER_16B_ASSERT_EN
  a_no_x: assert property (@(posedge clock) disable iff (!reset)
    !$isunknown({loadhigh, loadlow}));
  a_hi: assert property (@(posedge clock) disable iff (!reset)
    loadhigh |=> hi == $past(halfvaluein) && lo == $past(lo));
  a_lo: assert property (@(posedge clock) disable iff (!reset)
    loadlow && !loadhigh |=> lo == $past(halfvaluein) && $stable(hi));
  a_hold: assert property (@(posedge clock) disable iff (!reset)
    !loadhigh && !loadlow |=> $stable(valueout));
  always_comb
    if (!reset) a_rst: assert (valueout == (2*HALF_W)'(WORD_RESET));
`else
`endif
endmodule

// File: tb/tb_register_16b.sv
// tb_register_16b: directed vectors with a scoreboard queue checked by a separate monitor
module tb_register_16b;
  typedef struct {
    logic [15:0] exp;
    string       name;
  } item_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        loadhigh = 1'b0;
  logic        loadlow = 1'b0;
  logic [7:0]  halfvaluein = 8'h00;
  logic [15:0] valueout;
  item_t       sb[$];
  int          errors = 0;
  int          checks = 0;

  register_16b #(.HALF_W(8)) dut (
    .clock(clock), .reset(reset), .loadhigh(loadhigh), .loadlow(loadlow),
    .halfvaluein(halfvaluein), .valueout(valueout)
  );

  always #5 clock = ~clock;

  task automatic compare(input logic [15:0] exp, input string name);
    checks++;
    if (valueout !== exp) begin
      errors++;
      $display("FAIL %s: valueout=%h expected=%h", name, valueout, exp);
    end
  endtask

  // drive at the falling edge; the expected value appears after the next rising edge
  task automatic cyc(input logic rst, input logic lh, input logic ll, input logic [7:0] d,
                     input logic [15:0] exp, input string name);
    item_t it;
    @(negedge clock);
    reset = rst;
    loadhigh = lh;
    loadlow = ll;
    halfvaluein = d;
    it.exp = exp;
    it.name = name;
    sb.push_back(it);
  endtask

  initial begin
    item_t it;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() != 0) begin
        it = sb.pop_front();
        compare(it.exp, it.name);
      end
    end
  end

  initial begin
    item_t it;
    cyc(0, 0, 0, 8'hAA, 16'h0000, "reset");
    cyc(1, 0, 0, 8'h55, 16'h0000, "release_idle");
    cyc(1, 1, 0, 8'hFF, 16'hFF00, "hi_load");
    cyc(1, 0, 0, 8'hEE, 16'hFF00, "hi_hold");
    cyc(1, 0, 1, 8'hEE, 16'hFFEE, "lo_load");
    cyc(1, 0, 0, 8'h12, 16'hFFEE, "lo_hold");
    cyc(1, 1, 1, 8'h33, 16'h33EE, "precedence");
    cyc(1, 0, 0, 8'h77, 16'h33EE, "prec_hold");
    // async clear between edges with a low strobe held across release
    @(posedge clock);
    #2;
    reset = 1'b0;
    loadlow = 1'b1;
    halfvaluein = 8'h5A;
    #1;
    compare(16'h0000, "async_clear");
    @(negedge clock);
    compare(16'h0000, "async_held");
    reset = 1'b1;
    it.exp = 16'h005A;
    it.name = "release_load";
    sb.push_back(it);
    cyc(1, 0, 1, 8'hA5, 16'h00A5, "lo_reload");
    cyc(1, 1, 0, 8'hC3, 16'hC3A5, "hi_load2");
    cyc(1, 1, 0, 8'h3C, 16'h3CA5, "hi_reload");
    cyc(1, 0, 0, 8'h00, 16'h3CA5, "idle_data");
    cyc(0, 1, 1, 8'hFF, 16'h0000, "reset_over_load");
    cyc(1, 1, 0, 8'h81, 16'h8100, "release_hi_load");
    cyc(1, 0, 1, 8'h00, 16'h8100, "lo_zero");
    @(negedge clock);
    loadhigh = 1'b0;
    loadlow = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clock);
    #2;
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/register_16b.md
# register_16b

Byte-loadable 16-bit holding register for the 8-bit datapath. It assembles a 16-bit value, such as an address or a wide operand, from the 8-bit bus one half at a time. Each half is captured under its own load strobe. The full 16-bit value is presented continuously to downstream logic.

## Interface
- `HALF_W`, default 8: width of one half and of the input bus. The register is 2×`HALF_W` bits wide.
- `clock` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-low.
- `loadhigh` input 1: when high at a rising edge, load `halfvaluein` into the upper half.
- `loadlow` input 1: when high at a rising edge, load `halfvaluein` into the lower half (subject to precedence).
- `halfvaluein` input `HALF_W`: data bus sampled by either load.
- `valueout` output 2×`HALF_W`: current register contents, driven directly from flops.

## Operation
- Storage is two `HALF_W`-bit flop banks: `hi` maps to `valueout[2W-1:W]` and `lo` maps to `valueout[W-1:0]`.
- While `reset`=0, `valueout` = 0. This overrides all loads.
- At each rising `clock` edge with `reset`=1, the action depends on the two strobes:
  - `loadhigh`=1: `hi` ← `halfvaluein`; `lo` holds. `loadhigh` has precedence, so `lo` holds even when `loadlow`=1 in the same cycle.
  - `loadhigh`=0 and `loadlow`=1: `lo` ← `halfvaluein`; `hi` holds.
  - Both strobes 0: both halves hold.
- Holding the strobe high for several cycles reloads the selected half on every edge. Data changes on `halfvaluein` with no strobe asserted have no effect.
- There is no zero-extension or sign-extension. A load never alters the other half.

## Timing
- Reset assertion is asynchronous: `valueout` goes to 0 without waiting for a clock edge.
- Reset deassertion takes effect at the first rising edge after `reset` rises. A load strobe sampled at that edge is honored.
- Load latency is one cycle. Strobe and data are sampled at rising edge N, and the new value is visible on `valueout` after edge N (flop clock-to-q). There is no combinational path from inputs to `valueout`.
- Reset asserted mid-load, between edges, clears the register. The pending strobe is lost.
- Strobes and data must be stable around the rising edge. The bench drives them on the falling edge.

## Configuration
- `REGISTER_16B_ASSERT_EN`: when defined, compiles in concurrent assertions. They are disabled while `reset`=0.
  - No X on `loadhigh`/`loadlow` at a rising edge.
  - With `loadhigh`, next `hi` == past `halfvaluein` and next `lo` == past `lo`.
  - With `loadlow` and not `loadhigh`, next `lo` == past `halfvaluein` and `hi` stable.
  - With no strobe, `valueout` is stable.
  - While `reset`=0, `valueout`==0.
- When the macro is undefined, the RTL is purely synthesizable with no assertion code and identical functional behavior.

## Structure
- Shared package `register_16b_pkg` holds:
  - `HALF_W_DEFAULT` = 8.
  - `FULL_W_DEFAULT` = 16.
  - Typedefs `half_t` (logic[7:0]) and `word_t` (logic[15:0]).
  - The reset constant `WORD_RESET` = 16'h0000.
- Natural sub-module `reg_half_en`: a `HALF_W`-bit register with async active-low clear and a synchronous load enable. It is instantiated twice.
  - The top level computes the enables `hi_en = loadhigh` and `lo_en = loadlow & ~loadhigh`.

## Test plan
- Reset: drive `reset`=0 at a falling edge, then check after the next rising edge -> `valueout`=16'h0000. Release `reset` with no strobes -> stays 16'h0000.
- High load: `halfvaluein`=8'hFF, `loadhigh`=1 for one cycle -> 16'hFF00. Then `loadhigh`=0 with `halfvaluein`=8'hEE -> remains 16'hFF00.
- Low load: `halfvaluein`=8'hEE, `loadlow`=1 -> 16'hFFEE. Deassert `loadlow` and change the data -> remains 16'hFFEE.
- Precedence: from 16'hFFEE, `halfvaluein`=8'h33 with both strobes=1 -> 16'h33EE. The low half is unchanged.
- Async reset mid-operation: from 16'h33EE, pulse `reset`=0 between clock edges -> `valueout`=16'h0000 before the next rising edge. A `loadlow` strobe held across release with `halfvaluein`=8'h5A -> 16'h005A after the first edge with `reset`=1.
